// File: rtl/pulp_cluster_package.sv
// Shared types and constants for the cluster peripheral port arbiter.
package pulp_cluster_package;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        ERR  = 2'd3
    } per_arb_state_e;

    localparam logic [31:0] PER_ARB_ERR_RDATA = 32'hBADACCE5;

endpackage

// File: rtl/periph_port_rr_arbiter_rr_next_idx.sv
// Round-robin pick: first requester strictly after ptr_i, wrapping modulo N.
module rr_next_idx #(
    parameter int unsigned N     = 8,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic [N-1:0] rot;
    int unsigned  base;
    int unsigned  ffs;
    int unsigned  sum;

    always_comb begin
        // Rotate so the slot after ptr_i lands at bit 0; base may equal N (no rotation).
        base = 32'(ptr_i) + 1;
        rot  = N'({req_i, req_i} >> base);
        ffs  = 0;
        for (int unsigned k = N; k > 0; k--) begin
            if (rot[k-1]) begin
                ffs = k - 1;
            end
        end
        sum = base + ffs;
        if (sum >= N) begin
            sum = sum - N;
        end
        idx_o   = IDX_W'(sum);
        valid_o = |req_i;
    end

endmodule

// File: rtl/periph_port_rr_arbiter.sv
// Shares one peripheral target port among NB_INIT initiators: round-robin,
// single outstanding access, response steering and a stall watchdog.
module periph_port_rr_arbiter
    import pulp_cluster_package::*;
#(
    parameter int unsigned NB_INIT        = 8,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned BE_W           = DATA_W / 8,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NB_INIT-1:0]              init_req_i,
    input  logic [NB_INIT-1:0][ADDR_W-1:0]  init_add_i,
    input  logic [NB_INIT-1:0]              init_wen_i,
    input  logic [NB_INIT-1:0][DATA_W-1:0]  init_wdata_i,
    input  logic [NB_INIT-1:0][BE_W-1:0]    init_be_i,
    output logic [NB_INIT-1:0]              init_gnt_o,
    output logic [NB_INIT-1:0]              init_r_valid_o,
    output logic [DATA_W-1:0]               init_r_rdata_o,
    output logic                            init_r_opc_o,
    output logic                            tgt_req_o,
    output logic [ADDR_W-1:0]               tgt_add_o,
    output logic                            tgt_wen_o,
    output logic [DATA_W-1:0]               tgt_wdata_o,
    output logic [BE_W-1:0]                 tgt_be_o,
    input  logic                            tgt_gnt_i,
    input  logic                            tgt_r_valid_i,
    input  logic [DATA_W-1:0]               tgt_r_rdata_i,
    input  logic                            tgt_r_opc_i,
    output logic                            busy_o,
    output logic                            timeout_o
);

    localparam int unsigned      IDX_W    = (NB_INIT > 1) ? $clog2(NB_INIT) : 1;
    localparam int unsigned      CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(NB_INIT - 1);

    per_arb_state_e    state_q, state_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]  win_q, win_d;
    logic [ADDR_W-1:0] add_q, add_d;
    logic              wen_q, wen_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [IDX_W-1:0]   nxt_idx;
    logic               nxt_vld;
    logic               expire;
    logic               rsp_pass;
    logic               rsp_err;
    logic [NB_INIT-1:0] win_oh;

    rr_next_idx #(
        .N     (NB_INIT),
        .IDX_W (IDX_W)
    ) u_rr_next_idx (
        .req_i   (init_req_i),
        .ptr_i   (rr_ptr_q),
        .idx_o   (nxt_idx),
        .valid_o (nxt_vld)
    );

    assign win_oh   = NB_INIT'(1) << win_q;
    assign expire   = (TIMEOUT_CYCLES != 0) && ((state_q == REQ) || (state_q == RSP))
                      && (cnt_q == CNT_LAST);
    // Watchdog expiry takes precedence over a same-cycle target handshake.
    assign rsp_pass = (state_q == RSP) && !expire && tgt_r_valid_i;
    assign rsp_err  = (state_q == ERR) || ((state_q == RSP) && expire);

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        win_d    = win_q;
        add_d    = add_q;
        wen_d    = wen_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (nxt_vld) begin
                    state_d = REQ;
                    win_d   = nxt_idx;
                    add_d   = init_add_i[nxt_idx];
                    wen_d   = init_wen_i[nxt_idx];
                    wdata_d = init_wdata_i[nxt_idx];
                    be_d    = init_be_i[nxt_idx];
                    cnt_d   = '0;
                end
            end
            REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (expire) begin
                    state_d = ERR;
                end else if (tgt_gnt_i) begin
                    state_d = RSP;
                end
            end
            RSP: begin
                cnt_d = cnt_q + 1'b1;
                if (expire || tgt_r_valid_i) begin
                    state_d  = IDLE;
                    rr_ptr_d = win_q;
                end
            end
            ERR: begin
                state_d  = IDLE;
                rr_ptr_d = win_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            rr_ptr_q <= PTR_RST;
            win_q    <= '0;
            add_q    <= '0;
            wen_q    <= 1'b0;
            wdata_q  <= '0;
            be_q     <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            win_q    <= win_d;
            add_q    <= add_d;
            wen_q    <= wen_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            cnt_q    <= cnt_d;
        end
    end

    assign tgt_req_o   = (state_q == REQ) && !expire;
    assign tgt_add_o   = add_q;
    assign tgt_wen_o   = wen_q;
    assign tgt_wdata_o = wdata_q;
    assign tgt_be_o    = be_q;

    assign init_gnt_o     = ((state_q == REQ) && (tgt_gnt_i || expire)) ? win_oh : '0;
    assign init_r_valid_o = (rsp_pass || rsp_err) ? win_oh : '0;
    assign init_r_rdata_o = rsp_pass ? tgt_r_rdata_i
                          : (rsp_err ? DATA_W'(PER_ARB_ERR_RDATA) : '0);
    assign init_r_opc_o   = rsp_pass ? tgt_r_opc_i : rsp_err;

    assign busy_o    = (state_q != IDLE);
    assign timeout_o = expire;

endmodule

// File: tb/tb_periph_port_rr_arbiter.sv
// Directed bench for periph_port_rr_arbiter with hand-derived expectations.
module tb_periph_port_rr_arbiter;

    localparam int unsigned NB = 8;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 4;
    localparam int unsigned TO = 16;

    logic                   clk;
    logic                   rst_n;
    logic [NB-1:0]          init_req;
    logic [NB-1:0][AW-1:0]  init_add;
    logic [NB-1:0]          init_wen;
    logic [NB-1:0][DW-1:0]  init_wdata;
    logic [NB-1:0][BW-1:0]  init_be;
    logic [NB-1:0]          init_gnt_o;
    logic [NB-1:0]          init_r_valid_o;
    logic [DW-1:0]          init_r_rdata_o;
    logic                   init_r_opc_o;
    logic                   tgt_req_o;
    logic [AW-1:0]          tgt_add_o;
    logic                   tgt_wen_o;
    logic [DW-1:0]          tgt_wdata_o;
    logic [BW-1:0]          tgt_be_o;
    logic                   tgt_gnt_i;
    logic                   tgt_r_valid_i;
    logic [DW-1:0]          tgt_r_rdata_i;
    logic                   tgt_r_opc_i;
    logic                   busy_o;
    logic                   timeout_o;

    logic                   auto_tgt;
    logic                   man_gnt;
    logic                   man_rvalid;
    logic                   man_opc;
    logic [DW-1:0]          man_rdata;
    logic                   rv_pend;

    int vectors     = 0;
    int miscompares = 0;

    periph_port_rr_arbiter #(
        .NB_INIT        (NB),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .BE_W           (BW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .init_req_i     (init_req),
        .init_add_i     (init_add),
        .init_wen_i     (init_wen),
        .init_wdata_i   (init_wdata),
        .init_be_i      (init_be),
        .init_gnt_o     (init_gnt_o),
        .init_r_valid_o (init_r_valid_o),
        .init_r_rdata_o (init_r_rdata_o),
        .init_r_opc_o   (init_r_opc_o),
        .tgt_req_o      (tgt_req_o),
        .tgt_add_o      (tgt_add_o),
        .tgt_wen_o      (tgt_wen_o),
        .tgt_wdata_o    (tgt_wdata_o),
        .tgt_be_o       (tgt_be_o),
        .tgt_gnt_i      (tgt_gnt_i),
        .tgt_r_valid_i  (tgt_r_valid_i),
        .tgt_r_rdata_i  (tgt_r_rdata_i),
        .tgt_r_opc_i    (tgt_r_opc_i),
        .busy_o         (busy_o),
        .timeout_o      (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Auto target: grant immediately, respond in the following cycle.
    assign tgt_gnt_i     = auto_tgt ? tgt_req_o : man_gnt;
    assign tgt_r_valid_i = auto_tgt ? rv_pend : man_rvalid;
    assign tgt_r_rdata_i = man_rdata;
    assign tgt_r_opc_i   = man_opc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rv_pend <= 1'b0;
        else        rv_pend <= auto_tgt && tgt_req_o && tgt_gnt_i;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        init_req = '0; init_add = '0; init_wen = '0; init_wdata = '0; init_be = '0;
        auto_tgt = 1'b0; man_gnt = 1'b0; man_rvalid = 1'b0; man_opc = 1'b0; man_rdata = '0;
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if ({init_gnt_o, init_r_valid_o, init_r_rdata_o, init_r_opc_o, tgt_req_o, tgt_add_o,
             tgt_wen_o, tgt_wdata_o, tgt_be_o, busy_o, timeout_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: gnt=%h rv=%h rdata=%h req=%b add=%h busy=%b required all 0",
                     init_gnt_o, init_r_valid_o, init_r_rdata_o, tgt_req_o, tgt_add_o, busy_o);
        end
        tick;
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({busy_o, tgt_req_o, init_gnt_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_release_idle: busy=%b req=%b gnt=%h required 0", busy_o, tgt_req_o, init_gnt_o);
        end
        tick;
    endtask

    task automatic test_single_read;
        init_req[3] = 1'b1; init_add[3] = 32'h1020_0040; init_wen[3] = 1'b1;
        @(negedge clk);
        vectors++;
        if (tgt_req_o !== 1'b0) begin
            miscompares++;
            $display("FAIL read_latch_cycle: tgt_req=%b required 0", tgt_req_o);
        end
        tick;
        man_gnt = 1'b1;
        @(negedge clk);
        vectors++;
        if ({tgt_req_o, tgt_add_o, tgt_wen_o, init_gnt_o} !== {1'b1, 32'h1020_0040, 1'b1, 8'h08}) begin
            miscompares++;
            $display("FAIL read_req_gnt: req=%b add=%h wen=%b gnt=%h required 1 10200040 1 08",
                     tgt_req_o, tgt_add_o, tgt_wen_o, init_gnt_o);
        end
        tick;
        man_gnt = 1'b0; init_req[3] = 1'b0;
        @(negedge clk);
        vectors++;
        if ({tgt_req_o, init_gnt_o, init_r_valid_o, init_r_rdata_o} !== '0) begin
            miscompares++;
            $display("FAIL read_rsp_wait: req=%b gnt=%h rv=%h rdata=%h required 0",
                     tgt_req_o, init_gnt_o, init_r_valid_o, init_r_rdata_o);
        end
        tick;
        man_rvalid = 1'b1; man_rdata = 32'hCAFE_0001; man_opc = 1'b0;
        @(negedge clk);
        vectors++;
        if ({init_r_valid_o, init_r_rdata_o, init_r_opc_o} !== {8'h08, 32'hCAFE_0001, 1'b0}) begin
            miscompares++;
            $display("FAIL read_response: rv=%h rdata=%h opc=%b required 08 cafe0001 0",
                     init_r_valid_o, init_r_rdata_o, init_r_opc_o);
        end
        tick;
        man_rvalid = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy_o, init_r_valid_o, init_r_rdata_o, init_r_opc_o} !== '0) begin
            miscompares++;
            $display("FAIL read_back_idle: busy=%b rv=%h rdata=%h required 0", busy_o, init_r_valid_o, init_r_rdata_o);
        end
        tick;
    endtask

    task automatic test_back_to_back;
        int ngnt = 0;
        int last_c = 0;
        int last_idx = 0;
        logic [NB-1:0] exp_oh;
        test_reset;
        for (int i = 0; i < NB; i++) begin
            init_add[i] = 32'(i) << 8;
            init_wen[i] = 1'b1;
        end
        init_req = '1;
        auto_tgt = 1'b1;
        for (int c = 0; c < 27; c++) begin
            @(negedge clk);
            if (init_gnt_o != '0) begin
                exp_oh = 8'(1) << (ngnt % NB);
                vectors++;
                if ({init_gnt_o, tgt_add_o} !== {exp_oh, 32'(ngnt % NB) << 8}) begin
                    miscompares++;
                    $display("FAIL rr_order[%0d]: gnt=%h add=%h required %h %h",
                             ngnt, init_gnt_o, tgt_add_o, exp_oh, 32'(ngnt % NB) << 8);
                end
                if (ngnt > 0) begin
                    vectors++;
                    if (c - last_c !== 3) begin
                        miscompares++;
                        $display("FAIL rr_spacing[%0d]: gap=%0d required 3", ngnt, c - last_c);
                    end
                end
                last_idx = ngnt % NB;
                last_c = c;
                ngnt++;
            end
            if (init_r_valid_o != '0) begin
                vectors++;
                if (init_r_valid_o !== 8'(1) << last_idx) begin
                    miscompares++;
                    $display("FAIL rr_steer: rv=%h required %h", init_r_valid_o, 8'(1) << last_idx);
                end
            end
            tick;
        end
        init_req = '0;
        auto_tgt = 1'b0;
        @(negedge clk);
        vectors++;
        if ({ngnt, busy_o} !== {32'd9, 1'b0}) begin
            miscompares++;
            $display("FAIL rr_count: grants=%0d busy=%b required 9 0", ngnt, busy_o);
        end
        tick;
    endtask

    task automatic test_write_stall;
        init_req[5] = 1'b1; init_add[5] = 32'h2000_0010; init_wen[5] = 1'b0;
        init_wdata[5] = 32'h1234_5678; init_be[5] = 4'b0011;
        @(negedge clk);
        for (int c = 1; c <= 6; c++) begin
            tick;
            man_gnt = (c == 6);
            @(negedge clk);
            vectors++;
            if ({tgt_req_o, tgt_add_o, tgt_wen_o, tgt_wdata_o, tgt_be_o} !==
                {1'b1, 32'h2000_0010, 1'b0, 32'h1234_5678, 4'b0011}) begin
                miscompares++;
                $display("FAIL stall_fields[%0d]: req=%b add=%h wen=%b wdata=%h be=%b required 1 20000010 0 12345678 0011",
                         c, tgt_req_o, tgt_add_o, tgt_wen_o, tgt_wdata_o, tgt_be_o);
            end
            vectors++;
            if (init_gnt_o !== ((c == 6) ? 8'h20 : 8'h00)) begin
                miscompares++;
                $display("FAIL stall_gnt[%0d]: gnt=%h required %h", c, init_gnt_o, (c == 6) ? 8'h20 : 8'h00);
            end
        end
        tick;
        man_gnt = 1'b0; init_req[5] = 1'b0;
        tick;
        man_rvalid = 1'b1; man_rdata = 32'h0000_0000; man_opc = 1'b0;
        @(negedge clk);
        vectors++;
        if ({init_r_valid_o, init_r_opc_o} !== {8'h20, 1'b0}) begin
            miscompares++;
            $display("FAIL write_response: rv=%h opc=%b required 20 0", init_r_valid_o, init_r_opc_o);
        end
        tick;
        man_rvalid = 1'b0;
    endtask

    task automatic test_timeout_rsp;
        init_req[1] = 1'b1; init_add[1] = 32'h3000_0000; init_wen[1] = 1'b1;
        @(negedge clk);
        tick;
        man_gnt = 1'b1;
        @(negedge clk);
        vectors++;
        if (init_gnt_o !== 8'h02) begin
            miscompares++;
            $display("FAIL to_rsp_gnt: gnt=%h required 02", init_gnt_o);
        end
        tick;
        man_gnt = 1'b0; init_req[1] = 1'b0;
        for (int c = 2; c < 16; c++) begin
            @(negedge clk);
            vectors++;
            if ({timeout_o, init_r_valid_o} !== '0) begin
                miscompares++;
                $display("FAIL to_rsp_early[%0d]: timeout=%b rv=%h required 0 00", c, timeout_o, init_r_valid_o);
            end
            tick;
        end
        @(negedge clk);
        vectors++;
        if ({timeout_o, init_r_valid_o, init_r_opc_o, init_r_rdata_o} !== {1'b1, 8'h02, 1'b1, 32'hBADA_CCE5}) begin
            miscompares++;
            $display("FAIL to_rsp_expiry: timeout=%b rv=%h opc=%b rdata=%h required 1 02 1 badacce5",
                     timeout_o, init_r_valid_o, init_r_opc_o, init_r_rdata_o);
        end
        tick;
        @(negedge clk);
        vectors++;
        if ({busy_o, timeout_o} !== 2'b00) begin
            miscompares++;
            $display("FAIL to_rsp_idle: busy=%b timeout=%b required 0 0", busy_o, timeout_o);
        end
        tick;
        man_rvalid = 1'b1; man_rdata = 32'h1111_2222; man_opc = 1'b1;
        @(negedge clk);
        vectors++;
        if ({init_r_valid_o, init_r_rdata_o, init_r_opc_o} !== '0) begin
            miscompares++;
            $display("FAIL to_rsp_late_discard: rv=%h rdata=%h opc=%b required 0", init_r_valid_o, init_r_rdata_o, init_r_opc_o);
        end
        tick;
        man_rvalid = 1'b0; man_opc = 1'b0;
    endtask

    task automatic test_timeout_req;
        init_req[4] = 1'b1; init_add[4] = 32'h3000_0004; init_wen[4] = 1'b0;
        @(negedge clk);
        for (int c = 1; c < 16; c++) begin
            tick;
            @(negedge clk);
            vectors++;
            if ({tgt_req_o, init_gnt_o, timeout_o} !== {1'b1, 8'h00, 1'b0}) begin
                miscompares++;
                $display("FAIL to_req_wait[%0d]: req=%b gnt=%h timeout=%b required 1 00 0", c, tgt_req_o, init_gnt_o, timeout_o);
            end
        end
        tick;
        @(negedge clk);
        vectors++;
        if ({tgt_req_o, init_gnt_o, timeout_o, init_r_valid_o} !== {1'b0, 8'h10, 1'b1, 8'h00}) begin
            miscompares++;
            $display("FAIL to_req_expiry: req=%b gnt=%h timeout=%b rv=%h required 0 10 1 00",
                     tgt_req_o, init_gnt_o, timeout_o, init_r_valid_o);
        end
        tick;
        init_req[4] = 1'b0;
        @(negedge clk);
        vectors++;
        if ({init_r_valid_o, init_r_opc_o, init_r_rdata_o, timeout_o, init_gnt_o} !==
            {8'h10, 1'b1, 32'hBADA_CCE5, 1'b0, 8'h00}) begin
            miscompares++;
            $display("FAIL to_req_err_rsp: rv=%h opc=%b rdata=%h timeout=%b gnt=%h required 10 1 badacce5 0 00",
                     init_r_valid_o, init_r_opc_o, init_r_rdata_o, timeout_o, init_gnt_o);
        end
        tick;
        @(negedge clk);
        vectors++;
        if (busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL to_req_idle: busy=%b required 0", busy_o);
        end
        tick;
    endtask

    task automatic test_reset_mid;
        init_req[0] = 1'b1; init_add[0] = 32'h5000_0000; init_wen[0] = 1'b1;
        @(negedge clk);
        tick;
        man_gnt = 1'b1;
        @(negedge clk);
        vectors++;
        if (init_gnt_o !== 8'h01) begin
            miscompares++;
            $display("FAIL rstmid_gnt: gnt=%h required 01", init_gnt_o);
        end
        tick;
        man_gnt = 1'b0; init_req[0] = 1'b0;
        @(negedge clk);
        #2;
        man_rvalid = 1'b1; man_rdata = 32'hDEAD_BEEF;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({init_gnt_o, init_r_valid_o, init_r_rdata_o, init_r_opc_o, tgt_req_o, tgt_add_o,
             tgt_wen_o, tgt_wdata_o, tgt_be_o, busy_o, timeout_o} !== '0) begin
            miscompares++;
            $display("FAIL rstmid_async: gnt=%h rv=%h rdata=%h req=%b add=%h busy=%b required all 0",
                     init_gnt_o, init_r_valid_o, init_r_rdata_o, tgt_req_o, tgt_add_o, busy_o);
        end
        tick;
        man_rvalid = 1'b0; rst_n = 1'b1;
        init_add[2] = 32'h4000_0002; init_add[6] = 32'h4000_0006;
        init_req = 8'b0100_0100;
        @(negedge clk);
        tick;
        man_gnt = 1'b1;
        @(negedge clk);
        vectors++;
        if ({init_gnt_o, tgt_add_o} !== {8'h04, 32'h4000_0002}) begin
            miscompares++;
            $display("FAIL rstmid_first: gnt=%h add=%h required 04 40000002", init_gnt_o, tgt_add_o);
        end
        tick;
        man_gnt = 1'b0; init_req[2] = 1'b0; man_rvalid = 1'b1; man_rdata = 32'h0000_0022;
        @(negedge clk);
        vectors++;
        if ({init_r_valid_o, init_r_rdata_o} !== {8'h04, 32'h0000_0022}) begin
            miscompares++;
            $display("FAIL rstmid_rsp: rv=%h rdata=%h required 04 00000022", init_r_valid_o, init_r_rdata_o);
        end
        tick;
        man_rvalid = 1'b0;
        tick;
        man_gnt = 1'b1;
        @(negedge clk);
        vectors++;
        if ({init_gnt_o, tgt_add_o} !== {8'h40, 32'h4000_0006}) begin
            miscompares++;
            $display("FAIL rstmid_second: gnt=%h add=%h required 40 40000006", init_gnt_o, tgt_add_o);
        end
        tick;
        man_gnt = 1'b0; init_req = '0; man_rvalid = 1'b1;
        @(negedge clk);
        vectors++;
        if (init_r_valid_o !== 8'h40) begin
            miscompares++;
            $display("FAIL rstmid_second_rsp: rv=%h required 40", init_r_valid_o);
        end
        tick;
        man_rvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t required completion", $time);
        $fatal(1);
    end

    initial begin
        test_reset;
        test_single_read;
        test_back_to_back;
        test_write_stall;
        test_timeout_rsp;
        test_timeout_req;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/periph_port_rr_arbiter.md
Name: periph_port_rr_arbiter

Overview:
Shares one cluster-peripheral target port, such as a HWPE programming slave or the external-peripheral port, among NB_INIT core-side initiators.
- Sits in the peripheral interconnect, downstream of the address-to-port decode, one instance per shared target.
- Round-robin arbitration with a single outstanding transaction.
- Response steered back to the granted initiator.
- Timeout watchdog returns an error response if the target stalls.

Parameters:
NB_INIT, 8, number of initiators (≥2)
ADDR_W, 32, address width
DATA_W, 32, data width
BE_W, DATA_W/8, byte-enable width
TIMEOUT_CYCLES, 256, watchdog limit in cycles; 0 disables the watchdog
IDX_W, $clog2(NB_INIT), derived localparam: winner index width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
init_req_i  in  NB_INIT  per-initiator request
init_add_i  in  NB_INIT×ADDR_W  address
init_wen_i  in  NB_INIT  1=read, 0=write
init_wdata_i  in  NB_INIT×DATA_W  write data
init_be_i  in  NB_INIT×BE_W  byte enables
init_gnt_o  out  NB_INIT  grant, one-hot, one-cycle pulse
init_r_valid_o  out  NB_INIT  response valid, one-hot
init_r_rdata_o  out  DATA_W  response data, broadcast to all initiators
init_r_opc_o  out  1  response error flag, broadcast
tgt_req_o  out  1  target request
tgt_add_o  out  ADDR_W  target address
tgt_wen_o  out  1  target wen
tgt_wdata_o  out  DATA_W  target wdata
tgt_be_o  out  BE_W  target be
tgt_gnt_i  in  1  target grant
tgt_r_valid_i  in  1  target response valid
tgt_r_rdata_i  in  DATA_W  target read data
tgt_r_opc_i  in  1  target error flag
busy_o  out  1  FSM not in IDLE
timeout_o  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset (async, rst_ni=0):
  - FSM=IDLE; rr_ptr=NB_INIT-1, so initiator 0 has first priority.
  - Watchdog counter=0; latched request fields=0.
  - All outputs 0.
- Protocol: initiators hold req and fields stable until gnt. The target returns r_valid at least 1 cycle after its gnt.
- FSM states: IDLE, REQ, RSP, ERR.
- IDLE:
  - If any init_req_i is set, the winner is the first requester at or after (rr_ptr+1) mod NB_INIT.
  - Latch winner index, add, wen, wdata, be; go to REQ.
  - No output changes in this cycle.
- REQ:
  - tgt_req_o=1, driven from the latched fields, which stay stable until tgt_gnt_i.
  - On tgt_gnt_i: init_gnt_o[winner]=1 for exactly this cycle; go to RSP.
- RSP:
  - tgt_req_o=0.
  - On tgt_r_valid_i, in the same cycle (combinational pass-through):
    - init_r_valid_o[winner]=1;
    - init_r_rdata_o=tgt_r_rdata_i; init_r_opc_o=tgt_r_opc_i;
    - rr_ptr<=winner; go to IDLE.
- Latency and throughput:
  - gnt to the initiator at the earliest 2 cycles after its req rises (IDLE latch, then REQ).
  - Minimum 3 cycles per transaction.
- Watchdog:
  - Counter clears on entry to REQ and increments in REQ and RSP.
  - Expiry when count reaches TIMEOUT_CYCLES-1 with TIMEOUT_CYCLES≠0; timeout_o pulses in that cycle.
  - Expiry in REQ:
    - init_gnt_o[winner]=1 and tgt_req_o drops in that cycle; go to ERR.
    - ERR (1 cycle): init_r_valid_o[winner]=1, init_r_opc_o=1, rdata=PER_ARB_ERR_RDATA; rr_ptr<=winner; go to IDLE.
  - Expiry in RSP:
    - Immediate error response as in ERR; go to IDLE.
    - A late tgt_r_valid_i is then discarded.
- tgt_gnt_i in any state other than REQ, and tgt_r_valid_i in any state other than RSP, are ignored.
- No stray init_r_valid_o is ever produced.
- init_r_rdata_o/init_r_opc_o are 0 whenever no init_r_valid_o bit is set.
- An initiator dropping req before gnt is a protocol violation. The latched transaction completes regardless, and its gnt and response pulses are still issued.
- Reset mid-transaction aborts immediately. No gnt or response is issued for the aborted access.
- busy_o=(state≠IDLE).

Decomposition:
- pulp_cluster_package gets:
  - typedef enum logic [1:0] per_arb_state_e {IDLE, REQ, RSP, ERR};
  - localparam PER_ARB_ERR_RDATA=32'hBADACCE5.
- Sub-module rr_next_idx (combinational, params N, IDX_W):
  - inputs req vector and ptr;
  - outputs idx and valid;
  - rotate, find-first-set, un-rotate.
- The top level holds the FSM, latch registers, watchdog and response steering.

Test Plan:
- Reset, then init 3 reads 0x1020_0040:
  - tgt_req_o rises cycle 1 with add=0x1020_0040, wen=1;
  - tgt_gnt_i cycle 1 → init_gnt_o=0x08 cycle 1;
  - tgt_r_valid_i cycle 3 with rdata 0xCAFE0001 → init_r_valid_o=0x08, rdata=0xCAFE0001, opc=0, same cycle.
- All 8 initiators request continuously, target gnt/rsp immediate:
  - grant order 0,1,…,7,0;
  - exactly one gnt pulse per 3 cycles; no bit ever twice consecutively while others pend.
- Init 5 writes wdata 0x1234_5678, be=4'b0011; tgt_gnt_i held low 5 cycles:
  - tgt_req_o stays 1 and fields stay stable for 6 cycles;
  - no init_gnt_o until tgt_gnt_i.
- TIMEOUT_CYCLES=16, gnt given, r_valid never returned:
  - timeout_o and init_r_valid_o[winner] assert in the same cycle, 16 cycles after REQ entry;
  - opc=1, rdata=0xBADACCE5;
  - late tgt_r_valid_i 2 cycles later produces no init_r_valid_o.
- TIMEOUT_CYCLES=16, tgt_gnt_i never asserted:
  - gnt pulse and timeout_o in the same cycle;
  - error response on the next cycle; FSM back in IDLE.
- rst_ni asserted while in RSP:
  - all outputs 0 asynchronously;
  - after release, requests from initiators 2 and 6 give initiator 2 first (rr_ptr=7).
